cordic_sched: RTL and testbench
===============================

Name: cordic_sched

Overview:
- Shares one pipelined `cordic` core between N_REQ requesters.
- Grants requesters round-robin and drives the core's mode/x/y/z operands from a register.
- Tracks in-flight operations with a tag shift register, because the core has no valid signal.
- Routes res1/res2 back to the issuing requester as a one-cycle response pulse. A halt/drain control lets software quiesce the core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand/result width (8.8 sign-magnitude, matching the core).
- LATENCY, 16, fixed core latency: cycles from core_x/y/z/mode change until core_res1/res2 reflect it.
- ID_W, $clog2(N_REQ), requester index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  one-hot grant, combinational
- req_mode  in  N_REQ  per-requester CORDIC mode
- req_x / req_y / req_z  in  N_REQ*DATA_W each  flattened operands; requester i occupies slice [i*DATA_W +: DATA_W]
- rsp_valid  out  N_REQ  one-hot result pulse
- rsp_res1 / rsp_res2  out  DATA_W each  shared result bus
- halt  in  1  stop granting and drain
- halted  out  1  high when halt is set and the pipeline is empty
- core_mode  out  1  registered operand to the core
- core_x / core_y / core_z  out  DATA_W each  registered operands to the core
- core_res1 / core_res2  in  DATA_W each  core results

Behaviour:
- Reset values: all outputs 0, state=RUN, rr_ptr=N_REQ-1, tag pipeline cleared.
- Reset mid-operation drops all in-flight results; no rsp_valid is issued for them.
- FSM has two states, RUN and DRAIN.
  - RUN -> DRAIN when halt=1.
  - DRAIN -> RUN when halt=0, independent of pipeline occupancy.
  - halted = (state==DRAIN) && tag pipeline empty.
- Arbitration:
  - Only in RUN with halt=0.
  - Grant the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - req_ready[grant]=1 and all others are 0. req_ready depends on req_valid combinationally.
  - In DRAIN, and in RUN while halt=1, req_ready=0.
- Issue:
  - On a handshake edge: core_* <= granted requester's operands; rr_ptr <= grant; tag stage0 <= {1, grant}.
  - Otherwise tag stage0 valid <= 0, and core_* hold their previous values (no toggling).
  - At most one issue per cycle; the core is fully pipelined, so there is no back-pressure from it.
- Tag pipeline: LATENCY+1 stages of {vld, id}, shifting every cycle.
- Response:
  - When the last tag stage is valid: rsp_valid[id] <= 1, rsp_res1 <= core_res1, rsp_res2 <= core_res2.
  - Otherwise rsp_valid <= 0 and rsp_res* hold their values.
  - Latency: accept in cycle c, core_* valid in c+1, rsp_valid in c+LATENCY+2. Throughput is 1 result per cycle.
- Requesters must accept responses; there is no response back-pressure.
- Operands are passed through unmodified; no width or format conversion.
- Edge cases:
  - halt asserted in the same cycle as req_valid: no grant.
  - A single requester held valid continuously is granted every cycle.
  - All N_REQ requesting: grants rotate 0,1,...,N_REQ-1, each at 1/N_REQ share.

Optional Feature:
- Macro: CORDIC_SCHED_STATS_EN.
- When defined, adds out ports:
  - issue_cnt [15:0]: increments on each handshake, wraps at 0xFFFF->0.
  - stall_cnt [15:0]: increments on each cycle with |req_valid and no handshake, saturates at 0xFFFF.
  - Both counters clear on reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cordic_pkg holds:
  - DATA_W;
  - mode encoding constants CORDIC_MODE_ROT=1 and CORDIC_MODE_VEC=0;
  - typedef tag_t {logic vld; logic [ID_W-1:0] id}.
- One sub-module, rr_arbiter (N parameterised): inputs req and ptr, outputs one-hot grant and binary grant index; purely combinational.
- FSM, tag pipeline and operand registers stay in cordic_sched.

Test Plan:
- Single issue, bench core model with LATENCY=16.
  - Stimulus: requester 0, mode=1, x=0x1A60, y=0x0E00, z=0x0200, one cycle.
  - Required: req_ready[0]=1 same cycle; core_x=0x1A60 next cycle; rsp_valid=4'b0001 exactly 18 cycles after accept, with rsp_res1/res2 equal to the model output.
- Round-robin with all 4 requesters holding valid for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: rsp_valid one-hot in the same order, starting 18 cycles after the first accept.
- Back-to-back mixed operands.
  - Stimulus: req1 with z=0xF200, then req2 with x=0xF994, y=0x1EC1, z=0x05DF.
  - Required: two consecutive rsp_valid pulses (0010, then 0100) with the correct results; no bubble.
- Halt/drain.
  - Stimulus: halt=1 with 3 operations in flight.
  - Required: req_ready=0 immediately; 3 responses still delivered; halted=1 the cycle after the last tag leaves.
  - Stimulus: halt=0.
  - Required: halted=0 and grants resume from rr_ptr+1.
- Reset mid-flight: assert reset 5 cycles after an accept.
  - Required: all outputs 0 asynchronously; no rsp_valid afterwards; first grant after release goes to requester 0.
- Stats (CORDIC_SCHED_STATS_EN): 10 accepts plus 3 stalled cycles (halt=1 with req_valid=1).
  - Required: issue_cnt=10, stall_cnt=3.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared widths, CORDIC mode encoding and in-flight tag type
//               for the cordic_sched core-sharing scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  localparam int DATA_W = 16;

  localparam logic CORDIC_MODE_ROT = 1'b1;
  localparam logic CORDIC_MODE_VEC = 1'b0;

  // Tag id is sized for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/cordic_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; searches from ptr+1
//               upward (mod N) and returns a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          w_found;
  logic [IW-1:0] w_j;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = IW'((int'(ptr) + k) % N);
      if (!w_found && req[w_j]) begin
        w_found     = 1'b1;
        grant[w_j]  = 1'b1;
        idx         = w_j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_sched.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sched
// Description : Shares one fixed-latency pipelined CORDIC core between N_REQ
//               requesters with round-robin issue, tag tracking and halt/drain.
//               Optional counters: define CORDIC_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_sched #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = cordic_pkg::DATA_W,
  parameter int LATENCY = 16,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
`ifdef CORDIC_SCHED_STATS_EN
  output logic [15:0]             issue_cnt,
  output logic [15:0]             stall_cnt,
`endif
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_mode,
  input  logic [N_REQ*DATA_W-1:0] req_x,
  input  logic [N_REQ*DATA_W-1:0] req_y,
  input  logic [N_REQ*DATA_W-1:0] req_z,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_res1,
  output logic [DATA_W-1:0]       rsp_res2,
  input  logic                    halt,
  output logic                    halted,
  output logic                    core_mode,
  output logic [DATA_W-1:0]       core_x,
  output logic [DATA_W-1:0]       core_y,
  output logic [DATA_W-1:0]       core_z,
  input  logic [DATA_W-1:0]       core_res1,
  input  logic [DATA_W-1:0]       core_res2
);
  import cordic_pkg::*;

  localparam int TAG_IW = $bits(tag_t) - 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_gidx;
  logic [N_REQ-1:0] w_grant, w_rsp_hot;
  logic             w_arb_en, w_issue, w_busy;
  tag_t             r_tag [LATENCY+1];
  tag_t             w_tag_in, w_last;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_gidx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_arb_en = !halt;
        if (halt) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (!halt) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  assign req_ready    = w_arb_en ? w_grant : '0;
  assign w_issue      = |req_ready;
  assign w_tag_in.vld = w_issue;
  assign w_tag_in.id  = TAG_IW'(w_gidx);
  assign w_last       = r_tag[LATENCY];
  assign halted       = (r_state == ST_DRAIN) && !w_busy;

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s <= LATENCY; s++) w_busy = w_busy | r_tag[s].vld;
    for (int i = 0; i < N_REQ; i++) w_rsp_hot[i] = w_last.vld && (w_last.id == TAG_IW'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_rr_ptr <= ID_W'(N_REQ - 1);
      for (int s = 0; s <= LATENCY; s++) r_tag[s] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tag[0] <= w_tag_in;
      for (int s = 1; s <= LATENCY; s++) r_tag[s] <= r_tag[s-1];
      if (w_issue) r_rr_ptr <= w_gidx;
    end
  end

  // Operands hold between issues so the core inputs never toggle needlessly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_mode <= 1'b0;
      core_x    <= '0;
      core_y    <= '0;
      core_z    <= '0;
    end else if (w_issue) begin
      core_mode <= req_mode[w_gidx];
      core_x    <= req_x[int'(w_gidx)*DATA_W +: DATA_W];
      core_y    <= req_y[int'(w_gidx)*DATA_W +: DATA_W];
      core_z    <= req_z[int'(w_gidx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_res1  <= '0;
      rsp_res2  <= '0;
    end else begin
      rsp_valid <= w_rsp_hot;
      if (w_last.vld) begin
        rsp_res1 <= core_res1;
        rsp_res2 <= core_res2;
      end
    end
  end

`ifdef CORDIC_SCHED_STATS_EN
  // issue_cnt wraps naturally; stall_cnt saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_issue) issue_cnt <= issue_cnt + 16'd1;
      if (|req_valid && !w_issue && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_sched
// Description : Scoreboard bench for cordic_sched with a fixed-latency core
//               stand-in. Stats checks compile with CORDIC_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_sched;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 16;
  localparam int LATENCY = 16;
  localparam int RSP_LAT = LATENCY + 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_mode = '0;
  logic [N_REQ*DATA_W-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_res1, rsp_res2;
  logic                    halt = 1'b0;
  logic                    halted;
  logic                    core_mode;
  logic [DATA_W-1:0]       core_x, core_y, core_z, core_res1, core_res2;
`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0]             issue_cnt, stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [15:0] r1;
    logic [15:0] r2;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  cordic_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk       (clk),
`ifdef CORDIC_SCHED_STATS_EN
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt),
`endif
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_z     (req_z),
    .rsp_valid (rsp_valid),
    .rsp_res1  (rsp_res1),
    .rsp_res2  (rsp_res2),
    .halt      (halt),
    .halted    (halted),
    .core_mode (core_mode),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_z    (core_z),
    .core_res1 (core_res1),
    .core_res2 (core_res2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in core: an arbitrary deterministic function delayed by LATENCY cycles.
  function automatic logic [15:0] f1(input logic m, input logic [15:0] x, input logic [15:0] z);
    return x ^ {z[7:0], z[15:8]} ^ (m ? 16'h5A5A : 16'h0000);
  endfunction
  function automatic logic [15:0] f2(input logic m, input logic [15:0] y, input logic [15:0] z);
    return y + z + {15'd0, m};
  endfunction

  logic [15:0] m_r1 [LATENCY];
  logic [15:0] m_r2 [LATENCY];
  always @(posedge clk) begin
    m_r1[0] <= f1(core_mode, core_x, core_z);
    m_r2[0] <= f2(core_mode, core_y, core_z);
    for (int k = 1; k < LATENCY; k++) begin
      m_r1[k] <= m_r1[k-1];
      m_r2[k] <= m_r2[k-1];
    end
  end
  assign core_res1 = m_r1[LATENCY-1];
  assign core_res2 = m_r2[LATENCY-1];

  function automatic logic [N_REQ-1:0] oh(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Response monitor: every pulse must match the oldest expected result and arrive on time.
  always @(negedge clk) begin
    if (!reset && rsp_valid !== '0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: cycle %0d rsp_valid=%b, required no response", cyc, rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_valid !== oh(mon_e.id) || rsp_res1 !== mon_e.r1 || rsp_res2 !== mon_e.r2 || cyc != mon_e.due) begin
          miscompares++;
          $display("FAIL rsp_match: cycle %0d valid=%b res1=%h res2=%h, required cycle %0d valid=%b res1=%h res2=%h",
                   cyc, rsp_valid, rsp_res1, rsp_res2, mon_e.due, oh(mon_e.id), mon_e.r1, mon_e.r2);
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic m, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    req_mode[i] = m;
    req_x[i*DATA_W +: DATA_W] = x;
    req_y[i*DATA_W +: DATA_W] = y;
    req_z[i*DATA_W +: DATA_W] = z;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.id  = i;
    e.r1  = f1(req_mode[i], req_x[i*DATA_W +: DATA_W], req_z[i*DATA_W +: DATA_W]);
    e.r2  = f2(req_mode[i], req_y[i*DATA_W +: DATA_W], req_z[i*DATA_W +: DATA_W]);
    e.due = cyc + RSP_LAT;
    sb.push_back(e);
  endtask

  // Drives one cycle of requests; pushes the expected result when a grant is predicted.
  task automatic drive(input logic [N_REQ-1:0] mask, input int exp_id, output logic [N_REQ-1:0] seen);
    req_valid = mask;
    @(negedge clk);
    seen = req_ready;
    if (exp_id >= 0) push_exp(exp_id);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0;
    halt = 1'b0;
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, halted} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b halted=%b, required all 0", req_ready, rsp_valid, halted);
    end
    vectors++;
    if ({rsp_res1, rsp_res2} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: res1=%h res2=%h, required 0", rsp_res1, rsp_res2);
    end
    vectors++;
    if ({core_mode, core_x, core_y, core_z} !== '0) begin
      miscompares++;
      $display("FAIL reset_core: mode=%b x=%h y=%h z=%h, required 0", core_mode, core_x, core_y, core_z);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] seen;
    set_ops(0, 1'b1, 16'h1A60, 16'h0E00, 16'h0200);
    drive(4'b0001, 0, seen);
    vectors++;
    if (seen !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ready: got %b, required 0001", seen);
    end
    vectors++;
    if (core_x !== 16'h1A60 || core_y !== 16'h0E00 || core_z !== 16'h0200 || core_mode !== 1'b1) begin
      miscompares++;
      $display("FAIL single_core: mode=%b x=%h y=%h z=%h, required 1 1a60 0e00 0200", core_mode, core_x, core_y, core_z);
    end
    req_valid = '0;
    wait_drain("single");
    vectors++;
    if (core_x !== 16'h1A60) begin
      miscompares++;
      $display("FAIL single_hold: core_x=%h, required 1a60", core_x);
    end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] seen;
    apply_reset();
    for (int k = 0; k < N_REQ; k++)
      set_ops(k, logic'(k % 2), 16'(16'h0110 * (k + 1)), 16'(16'h0203 * (k + 3)), 16'(16'h3001 + k));
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, k % N_REQ, seen);
      vectors++;
      if (seen !== oh(k % N_REQ)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %b, required %b", k, seen, oh(k % N_REQ));
      end
    end
    req_valid = '0;
    wait_drain("rr");
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] seen1, seen2;
    set_ops(1, 1'b1, 16'h1000, 16'h0800, 16'hF200);
    set_ops(2, 1'b0, 16'hF994, 16'h1EC1, 16'h05DF);
    drive(4'b0010, 1, seen1);
    drive(4'b0100, 2, seen2);
    vectors++;
    if (seen1 !== 4'b0010 || seen2 !== 4'b0100) begin
      miscompares++;
      $display("FAIL b2b_grant: got %b then %b, required 0010 then 0100", seen1, seen2);
    end
    req_valid = '0;
    wait_drain("b2b");
  endtask

  task automatic test_halt();
    logic [N_REQ-1:0] seen;
    int last_due;
    int bad_ready;
    bad_ready = 0;
    drive(4'b1111, 3, seen);
    drive(4'b1111, 0, seen);
    drive(4'b1111, 1, seen);
    last_due = sb[$].due;
    halt = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (req_ready !== '0) bad_ready++;
      if (cyc == last_due - 1) begin
        vectors++;
        if (halted !== 1'b0) begin
          miscompares++;
          $display("FAIL halt_early: halted=%b with a tag in flight, required 0", halted);
        end
      end
      if (cyc == last_due) begin
        vectors++;
        if (halted !== 1'b1) begin
          miscompares++;
          $display("FAIL halt_done: halted=%b after last tag left, required 1", halted);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (bad_ready != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL halt_drain: %0d ready cycles, %0d responses missing, required 0 and 0", bad_ready, sb.size());
    end
    halt = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    vectors++;
    if (halted !== 1'b0 || req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL halt_resume: halted=%b ready=%b, required 0 and 0100", halted, req_ready);
    end
    push_exp(2);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain("resume");
  endtask

  task automatic test_reset_midflight();
    logic [N_REQ-1:0] seen;
    int rsp_seen;
    rsp_seen = 0;
    drive(4'b0001, 0, seen);
    req_valid = '0;
    vectors++;
    if (seen !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_accept: got %b, required 0001", seen);
    end
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({core_mode, core_x, core_y, core_z, rsp_valid, rsp_res1, rsp_res2, req_ready, halted} !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: core_x=%h rsp_valid=%b res1=%h ready=%b, required all 0", core_x, rsp_valid, rsp_res1, req_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rsp_valid !== '0) rsp_seen++;
    end
    vectors++;
    if (rsp_seen != 0) begin
      miscompares++;
      $display("FAIL midrst_dropped: %0d response cycles after reset, required 0", rsp_seen);
    end
    @(posedge clk); #1;
    drive(4'b1111, 0, seen);
    req_valid = '0;
    vectors++;
    if (seen !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_first_grant: got %b, required 0001", seen);
    end
    wait_drain("midrst");
  endtask

`ifdef CORDIC_SCHED_STATS_EN
  task automatic test_stats();
    logic [N_REQ-1:0] seen;
    int bad;
    bad = 0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      drive(4'b0001, 0, seen);
      if (seen !== 4'b0001) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stats_single_stream: %0d cycles without grant, required 0", bad);
    end
    halt = 1'b1;
    for (int k = 0; k < 3; k++) drive(4'b0001, -1, seen);
    req_valid = '0;
    @(negedge clk);
    vectors++;
    if (issue_cnt !== 16'd10 || stall_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL stats_counts: issue_cnt=%0d stall_cnt=%0d, required 10 and 3", issue_cnt, stall_cnt);
    end
    @(posedge clk); #1;
    halt = 1'b0;
    wait_drain("stats");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_halt();
    test_reset_midflight();
`ifdef CORDIC_SCHED_STATS_EN
    test_stats();
`endif
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
